// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
// Shares the single-port CPU work RAM between the Z80 game core and the
// hiscore engine. A hiscore pause request becomes a CPU pause at the next
// CPU bus-cycle boundary. After a fixed drain interval the RAM port is handed
// to the hiscore side. When the hiscore side lets go, ownership returns to the
// CPU at the following bus-cycle boundary.
//
// Hiscore access handshake (strobe/ack, one transaction at a time):
//   - In HS, with no access outstanding, a 1-cycle hs_write or hs_read is accepted.
//     hs_write wins if both strobes are high in the same cycle.
//   - A write drives ram_we only in the strobe cycle. hs_ack pulses in the next cycle.
//   - A read drives the address in strobe cycle N. ram_dout is captured into
//     hs_data_out at the end of N+1, and hs_ack pulses in N+2.
//   - The engine counts as busy from the strobe up to and including the ack
//     cycle. Strobes seen while busy, or outside HS, are dropped and get no ack.
module hs_ram_arbiter #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int DRAIN = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    // CPU side
    input  logic          cpu_ce,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    // hiscore side
    input  logic          hs_pause,
    input  logic [15:0]   hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    input  logic          hs_read,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_ack,
    output logic          hs_granted,
    // pause block
    output logic          pause_cpu,
    // RAM macro (synchronous read, 1-cycle latency)
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    // debug: current ownership state (0=CPU, 1=DRAIN, 2=HS, 3=REL)
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HS    = 2'd2,
        ST_REL   = 2'd3
    } state_t;

    // The last count value seen in DRAIN before the hand-over to the hiscore side.
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

    state_t      state, state_nx;
    logic [3:0]  drain_cnt, drain_cnt_nx;
    logic        pause_nx;
    logic        granted_nx;

    // An accepted read waits in pend_rd for the RAM data.
    logic        pend_rd;
    logic        hs_busy;
    logic        hs_accept;
    logic        acc_wr;
    logic        acc_rd;

    // Address bits above AW are ignored. There is no range check.
    logic        unused_hs_hi;
    assign unused_hs_hi = ^hs_address[15:AW];

    assign fsm_state = state;

    // hiscore strobe acceptance: only in HS, and only when no access is outstanding
    always_comb begin
        hs_busy   = pend_rd | hs_ack;
        hs_accept = (state == ST_HS) && !hs_busy && (hs_write || hs_read);
        acc_wr    = hs_accept && hs_write;
        acc_rd    = hs_accept && hs_read && !hs_write;
    end

    // RAM port mux and CPU read-data return, selected by the ownership state
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        cpu_dout = ram_dout;
        case (state)
            ST_CPU: begin
                ram_we = cpu_we & cpu_ce;
            end
            ST_DRAIN, ST_REL: begin
                // The CPU stays on the mux, but it cannot write while it is held.
                ram_we = 1'b0;
            end
            ST_HS: begin
                ram_addr = hs_address[AW-1:0];
                ram_din  = hs_data_in;
                ram_we   = acc_wr;
                cpu_dout = '0;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // ownership next-state logic; pause_cpu and hs_granted move only on these transitions
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        pause_nx     = pause_cpu;
        granted_nx   = hs_granted;
        case (state)
            ST_CPU: begin
                // Switch only on a bus-cycle boundary. The access on this cpu_ce still completes.
                if (hs_pause && cpu_ce) begin
                    state_nx     = ST_DRAIN;
                    pause_nx     = 1'b1;
                    drain_cnt_nx = '0;
                end
            end
            ST_DRAIN: begin
                if (!hs_pause) begin
                    state_nx     = ST_REL;
                    drain_cnt_nx = '0;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nx     = ST_HS;
                    granted_nx   = 1'b1;
                    drain_cnt_nx = '0;
                end else begin
                    drain_cnt_nx = drain_cnt + 4'd1;
                end
            end
            ST_HS: begin
                // A read in flight, or a strobe accepted this cycle, holds the
                // port until the ack cycle.
                if (!hs_pause && !pend_rd && !hs_accept) begin
                    state_nx   = ST_REL;
                    granted_nx = 1'b0;
                end
            end
            ST_REL: begin
                if (cpu_ce) begin
                    state_nx = ST_CPU;
                    pause_nx = 1'b0;
                end
            end
            default: begin
                state_nx     = ST_CPU;
                pause_nx     = 1'b0;
                granted_nx   = 1'b0;
                drain_cnt_nx = '0;
            end
        endcase
    end

    // ownership state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_CPU;
            drain_cnt  <= '0;
            pause_cpu  <= 1'b0;
            hs_granted <= 1'b0;
        end else begin
            state      <= state_nx;
            drain_cnt  <= drain_cnt_nx;
            pause_cpu  <= pause_nx;
            hs_granted <= granted_nx;
        end
    end

    // hiscore access pipeline: read-data capture and ack generation
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_rd     <= 1'b0;
            hs_ack      <= 1'b0;
            hs_data_out <= '0;
        end else begin
            pend_rd <= acc_rd;
            hs_ack  <= acc_wr | pend_rd;
            if (pend_rd) begin
                hs_data_out <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter
// Directed sequence with randomized addresses and data for hs_ram_arbiter.
// A shadow memory holds the contents the RAM must have, following the ownership
// rules. The bench queues the expected hiscore read data and checks it when the ack arrives.
module tb_hs_ram_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DRAIN = 4;

    // clock / reset
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    logic reset;

    logic          cpu_ce;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic [DW-1:0] cpu_dout;
    logic          hs_pause;
    logic [15:0]   hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic          hs_read;
    logic [DW-1:0] hs_data_out;
    logic          hs_ack;
    logic          hs_granted;
    logic          pause_cpu;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic [1:0]    fsm_state;

    hs_ram_arbiter #(.AW(AW), .DW(DW), .DRAIN(DRAIN)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_ce      (cpu_ce),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_we      (cpu_we),
        .cpu_dout    (cpu_dout),
        .hs_pause    (hs_pause),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_write    (hs_write),
        .hs_read     (hs_read),
        .hs_data_out (hs_data_out),
        .hs_ack      (hs_ack),
        .hs_granted  (hs_granted),
        .pause_cpu   (pause_cpu),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout),
        .fsm_state   (fsm_state)
    );

    // synchronous single-port RAM macro
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // scoreboard
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_addrs[$];
    logic [DW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ce   = 1'b0;
        cpu_we   = 1'b0;
        hs_write = 1'b0;
        hs_read  = 1'b0;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        cpu_ce   = 1'b1;
        settle();
        chk("cpu_we", 32'(ram_we), 32'd1);
        ref_mem[a] = d;
        wr_addrs.push_back(a);
        cyc();
        idle_inputs();
    endtask

    task automatic cpu_read_chk(input string tag, input logic [AW-1:0] a);
        cpu_addr = a;
        cpu_we   = 1'b0;
        cpu_ce   = 1'b1;
        cyc();
        cpu_ce = 1'b0;
        chk(tag, 32'(cpu_dout), 32'(ref_mem[a]));
    endtask

    task automatic hs_write_op(input logic [15:0] a16, input logic [DW-1:0] d);
        logic [AW-1:0] a;
        a          = a16[AW-1:0];
        hs_address = a16;
        hs_data_in = d;
        hs_write   = 1'b1;
        settle();
        chk("hs_we", 32'(ram_we), 32'd1);
        chk("hs_waddr", 32'(ram_addr), 32'(a));
        ref_mem[a] = d;
        wr_addrs.push_back(a);
        cyc();
        hs_write = 1'b0;
        chk("hs_wack", 32'(hs_ack), 32'd1);
        cyc();
        chk("hs_wack_end", 32'(hs_ack), 32'd0);
    endtask

    task automatic hs_read_op(input logic [15:0] a16);
        exp_q.push_back(ref_mem[a16[AW-1:0]]);
        hs_address = a16;
        hs_read    = 1'b1;
        cyc();
        hs_read = 1'b0;
        chk("hs_rack_early", 32'(hs_ack), 32'd0);
        cyc();
        chk("hs_rack", 32'(hs_ack), 32'd1);
        chk("hs_rdata", 32'(hs_data_out), 32'(exp_q.pop_front()));
        cyc();
        chk("hs_rack_end", 32'(hs_ack), 32'd0);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [15:0]   a16;
        logic [DW-1:0] exp_d;

        idle_inputs();
        hs_pause   = 1'b0;
        hs_address = '0;
        hs_data_in = '0;
        cpu_addr   = '0;
        cpu_din    = '0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

        // reset
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_pause", 32'(pause_cpu), 32'd0);
        chk("rst_granted", 32'(hs_granted), 32'd0);
        chk("rst_ack", 32'(hs_ack), 32'd0);
        chk("rst_dout", 32'(hs_data_out), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        reset = 1'b0;
        cyc();

        // CPU write then read back, no pause
        cpu_write(11'h123, 8'h5A);
        chk("t1_pause_w", 32'(pause_cpu), 32'd0);
        cpu_read_chk("t1_read", 11'h123);
        chk("t1_pause_r", 32'(pause_cpu), 32'd0);
        cpu_we = 1'b1;
        settle();
        chk("t1_we_no_ce", 32'(ram_we), 32'd0);
        cpu_we = 1'b0;
        cpu_write(11'h020, 8'h11);
        cpu_write(11'h040, 8'h22);
        for (int i = 0; i < 6; i++) begin
            a = 11'($urandom_range(0, (1 << AW) - 1));
            d = 8'($urandom);
            cpu_write(a, d);
            if ($urandom_range(0, 1) == 1) cyc();
            cpu_read_chk("t1_rand_read", a);
        end

        // pause request between cpu_ce pulses
        hs_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_pause_wait", 32'(pause_cpu), 32'd0);
            chk("t2_grant_wait", 32'(hs_granted), 32'd0);
        end
        d = 8'($urandom);
        cpu_write(11'h300, d);
        chk("t2_pause_rise", 32'(pause_cpu), 32'd1);
        chk("t2_grant_k0", 32'(hs_granted), 32'd0);
        // strobe during DRAIN, CPU write attempt while held
        hs_address = 16'h0020;
        hs_data_in = 8'hEE;
        hs_write   = 1'b1;
        cpu_addr   = 11'h040;
        cpu_din    = 8'h99;
        cpu_we     = 1'b1;
        cpu_ce     = 1'b1;
        settle();
        chk("t5_drain_we", 32'(ram_we), 32'd0);
        cyc();
        idle_inputs();
        chk("t5_drain_ack", 32'(hs_ack), 32'd0);
        chk("t2_grant_k1", 32'(hs_granted), 32'd0);
        for (int k = 2; k <= DRAIN; k++) begin
            cyc();
            chk("t2_grant_count", 32'(hs_granted), 32'(k == DRAIN));
        end
        chk("t2_pause_hold", 32'(pause_cpu), 32'd1);

        // hiscore write then read
        hs_write_op(16'h0010, 8'hA5);
        hs_read_op(16'h0010);

        // second strobe while a read is busy, held through the ack cycle
        hs_address = 16'h0010;
        hs_read    = 1'b1;
        cyc();
        hs_read    = 1'b0;
        hs_write   = 1'b1;
        hs_data_in = 8'h33;
        settle();
        chk("t5_busy_we", 32'(ram_we), 32'd0);
        cyc();
        settle();
        chk("t5_busy_we_ack", 32'(ram_we), 32'd0);
        chk("t5_busy_rack", 32'(hs_ack), 32'd1);
        chk("t5_busy_rdata", 32'(hs_data_out), 32'(ref_mem[11'h010]));
        cyc();
        hs_write = 1'b0;
        chk("t5_no_extra_ack", 32'(hs_ack), 32'd0);

        // both strobes together: write wins, read dropped
        d          = 8'($urandom);
        hs_address = 16'h0050;
        hs_data_in = d;
        hs_write   = 1'b1;
        hs_read    = 1'b1;
        settle();
        chk("rw_we", 32'(ram_we), 32'd1);
        ref_mem[11'h050] = d;
        wr_addrs.push_back(11'h050);
        cyc();
        idle_inputs();
        chk("rw_ack", 32'(hs_ack), 32'd1);
        cyc();
        chk("rw_ack_end", 32'(hs_ack), 32'd0);
        chk("rw_dout_hold", 32'(hs_data_out), 32'(ref_mem[11'h010]));

        // address truncation
        d = 8'($urandom);
        hs_write_op(16'hF811, d);
        hs_read_op(16'h0011);

        // random hiscore traffic
        for (int i = 0; i < 16; i++) begin
            a16 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                hs_write_op(a16, 8'($urandom));
            end else begin
                a16[AW-1:0] = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                hs_read_op(a16);
            end
        end
        chk("hs_grant_held", 32'(hs_granted), 32'd1);

        // pause drops while a read is in flight
        exp_d      = ref_mem[11'h010];
        hs_address = 16'h0010;
        hs_read    = 1'b1;
        cyc();
        hs_read  = 1'b0;
        hs_pause = 1'b0;
        chk("t4_ack_early", 32'(hs_ack), 32'd0);
        chk("t4_grant_n1", 32'(hs_granted), 32'd1);
        cyc();
        chk("t4_ack", 32'(hs_ack), 32'd1);
        chk("t4_rdata", 32'(hs_data_out), 32'(exp_d));
        chk("t4_grant_ack", 32'(hs_granted), 32'd1);
        cyc();
        chk("t4_rel_grant", 32'(hs_granted), 32'd0);
        chk("t4_rel_pause", 32'(pause_cpu), 32'd1);
        chk("t4_rel_ack", 32'(hs_ack), 32'd0);
        cyc();
        chk("t4_rel_wait", 32'(pause_cpu), 32'd1);
        cpu_addr = 11'h010;
        cpu_we   = 1'b0;
        cpu_ce   = 1'b1;
        settle();
        chk("t4_rel_addr", 32'(ram_addr), 32'h010);
        chk("t4_rel_we", 32'(ram_we), 32'd0);
        cyc();
        cpu_ce = 1'b0;
        chk("t4_unpause", 32'(pause_cpu), 32'd0);
        chk("t4_cpu_read", 32'(cpu_dout), 32'(exp_d));
        cpu_read_chk("drain_blocked_hs", 11'h020);
        cpu_read_chk("drain_blocked_cpu", 11'h040);
        cpu_read_chk("pause_edge_write", 11'h300);

        // pause withdrawn during DRAIN
        hs_pause = 1'b1;
        cpu_ce   = 1'b1;
        cyc();
        cpu_ce = 1'b0;
        chk("abort_pause", 32'(pause_cpu), 32'd1);
        cyc();
        hs_pause = 1'b0;
        cyc();
        chk("abort_rel_state", 32'(fsm_state), 32'd3);
        for (int i = 0; i < DRAIN + 2; i++) cyc();
        chk("abort_grant", 32'(hs_granted), 32'd0);
        chk("abort_pause_hold", 32'(pause_cpu), 32'd1);
        cpu_ce = 1'b1;
        cyc();
        cpu_ce = 1'b0;
        chk("abort_unpause", 32'(pause_cpu), 32'd0);

        // reset in HS during a write
        hs_pause = 1'b1;
        cpu_ce   = 1'b1;
        cyc();
        cpu_ce = 1'b0;
        for (int i = 0; i < DRAIN; i++) cyc();
        chk("t6_granted", 32'(hs_granted), 32'd1);
        hs_address = 16'h07F0;
        hs_data_in = 8'h77;
        hs_write   = 1'b1;
        reset      = 1'b1;
        cyc();
        reset    = 1'b0;
        hs_write = 1'b0;
        settle();
        chk("t6_ack", 32'(hs_ack), 32'd0);
        chk("t6_granted_rst", 32'(hs_granted), 32'd0);
        chk("t6_pause", 32'(pause_cpu), 32'd0);
        chk("t6_dout", 32'(hs_data_out), 32'd0);
        chk("t6_state", 32'(fsm_state), 32'd0);
        chk("t6_we", 32'(ram_we), 32'd0);
        hs_pause = 1'b0;
        cyc();
        chk("t6_no_late_ack", 32'(hs_ack), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
